// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction-memory write path (prog_loader)
// and the fetch/decode side (control).
//   INSTR_W         instruction word width
//   loader_state_t  prog_loader FSM states
//   *_MSB / *_LSB   instruction field positions; imm overlaps the register
//                   fields and is only meaningful in immediate-form instructions
package cpu_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int FUNC_MSB   = 31;
    localparam int FUNC_LSB   = 28;
    localparam int TYPE_MSB   = 27;
    localparam int TYPE_LSB   = 26;
    localparam int OPCODE_MSB = 25;
    localparam int OPCODE_LSB = 20;
    localparam int RD_MSB     = 19;
    localparam int RD_LSB     = 15;
    localparam int R1_MSB     = 14;
    localparam int R1_LSB     = 10;
    localparam int HI_MSB     = 9;
    localparam int HI_LSB     = 9;
    localparam int R2_MSB     = 8;
    localparam int R2_LSB     = 4;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles a little-endian 32-bit word from a byte stream.
// Bytes land in lane idx (0..3); idx advances on every push. A word is
// presented (word_valid) on the push that fills lane 3 or carries last; any
// lane above the current one is presented as zero.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           restart assembly at lane 0
//   push, data      byte transfer and its value
//   last            this push is the final byte of the image
//   word            assembled word (valid together with word_valid)
//   word_valid      a word completes on this push
//   partial         the completing push is not in lane 3
module byte_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               last,
    input  logic [7:0]         data,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid,
    output logic               partial
);

    logic [1:0] idx_q;
    logic [7:0] lane_q [0:2];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 2'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
        end else if (push) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // NOTE: the lane holding registers are pure datapath and carry no reset;
    // a lane is only ever read after it was written in the current word.
    always_ff @(posedge clk) begin
        if (push && idx_q != 2'd3) begin
            lane_q[idx_q] <= data;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        word = '0;
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < idx_q) begin
                word[8*k +: 8] = lane_q[k];
            end
        end
        word[{idx_q, 3'b000} +: 8] = data;
        word_valid = push && (idx_q == 2'd3 || last);
        partial    = (idx_q != 2'd3);
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: fills the instruction memory from a little-endian byte stream,
// holding the CPU off until the image is fully written.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           pulse: begin a load (honoured in IDLE and DONE only)
//   s_data/s_valid/s_last/s_ready   byte stream, transfer on s_valid && s_ready
//   mem_we/mem_addr/mem_wdata       one-cycle instruction-memory write
//   cpu_enable      releases control once the load has completed
//   done            load complete
//   words_loaded    writes issued in the current/last load, saturates at DEPTH
//   err_partial     sticky: image length not a multiple of 4 bytes
//   err_ovf         sticky: image longer than DEPTH words
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_enable,
    output logic               done,
    output logic [ADDR_W:0]    words_loaded,
    output logic               err_partial,
    output logic               err_ovf
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    loader_state_t      state_q, state_d;
    logic               clear;
    logic               xfer;
    logic [INSTR_W-1:0] word;
    logic               word_valid;
    logic               partial;

    // s_ready is only ever high in LOAD, so it alone qualifies a transfer.
    assign xfer = s_valid && s_ready;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (xfer),
        .last       (s_last),
        .data       (s_data),
        .word       (word),
        .word_valid (word_valid),
        .partial    (partial)
    );

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (xfer && s_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state, so s_ready rises one
    // edge after start and cpu_enable rises only after the final write edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_enable   <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            err_partial  <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_ready    <= (state_d == LOAD);
            cpu_enable <= (state_d == DONE);
            done       <= (state_d == DONE);
            mem_we     <= 1'b0;
            if (clear) begin
                mem_addr     <= '0;
                words_loaded <= '0;
                err_partial  <= 1'b0;
                err_ovf      <= 1'b0;
            end else if (word_valid) begin
                if (partial) begin
                    err_partial <= 1'b1;
                end
                // words_loaded doubles as the next write address; it stops at
                // DEPTH so the address never wraps back onto written words.
                if (words_loaded < DEPTH_W) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= words_loaded[ADDR_W-1:0];
                    mem_wdata    <= word;
                    words_loaded <= words_loaded + 1'b1;
                end else begin
                    err_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware program loader that fills the CPU instruction memory from a byte stream and then releases the CPU. It is the write side of the `instr_cache` fetch path: `control` reads `instr_cache.memory_bank`, and this block writes it. While a load runs, `control` is held off with `enable` low. Bytes arrive in the same little-endian order as a raw program image, so a 32-bit word is `{b3, b2, b1, b0}`.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction memory word-address width.
- `DEPTH`, default 1024: number of writable words; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a load.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_last`  in  1  final byte of the image; qualified by `s_valid`.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  word to write.
- `cpu_enable`  out  1  drives `control.enable`.
- `done`  out  1  load complete.
- `words_loaded`  out  ADDR_W+1  words written in the last or current load.
- `err_partial`  out  1  sticky flag: image length was not a multiple of 4.
- `err_ovf`  out  1  sticky flag: image exceeded `DEPTH` words.

## Operation
- All outputs are registered. Reset values: state `IDLE`, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_enable`=0, `done`=0, `words_loaded`=0, both error flags 0.
- A byte transfer happens on a rising edge where `s_valid && s_ready`.
- States:
  - `IDLE`: `s_ready`=0. `start` moves to `LOAD` and clears the byte index, word address, `words_loaded` and the error flags.
  - `LOAD`: `s_ready`=1. Each accepted byte goes into lane `idx` (0..3), then `idx` increments modulo 4.
    - On a transfer with `idx`=3, or with `s_last`, the assembled word is issued as a write.
    - Lanes not yet filled are written as zero.
    - A write issued when `idx` is not 3 sets `err_partial`.
    - A transfer with `s_last` moves to `FLUSH`.
  - `FLUSH`: `s_ready`=0. Lets the final `mem_we` complete, then moves to `DONE`.
  - `DONE`: `cpu_enable`=1, `done`=1. `start` returns to `LOAD` and drops `cpu_enable` and `done` on the same edge.
- `start` received while in `LOAD` or `FLUSH` is ignored.
- Write addresses start at 0 and increment by 1 after each issued write. `words_loaded` counts issued writes and saturates at `DEPTH`.
- Overflow: once `DEPTH` words have been written, further completed words are not written (`mem_we` stays 0) and `err_ovf` is set. Bytes are still accepted until `s_last`, so the stream always drains. `mem_addr` never wraps.
- Reset asserted mid-load immediately returns every output to its reset value. Memory contents are left as they are.

## Timing
- Byte accepted at edge t that completes a word: `mem_we`=1 with `mem_addr`/`mem_wdata` valid from t to t+1; the memory captures at t+1. `mem_we` is a one-cycle pulse.
- Sustained throughput is one byte per cycle. Back-to-back words give one `mem_we` every 4 cycles. `s_ready` does not drop between words.
- `s_last` at edge t: final `mem_we` runs t..t+1 (`FLUSH`). `DONE` with `cpu_enable`=1 starts after t+1, so the CPU's first fetch sees fully written memory.
- `start` to `s_ready`=1: one edge.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W` = 32.
  - Loader state enum: `IDLE`, `LOAD`, `FLUSH`, `DONE`.
  - Instruction field-position constants (func, type, opcode, rd, r1, hi, r2, imm), also used by `control`.
- One sub-module, `byte_packer`: 4-lane little-endian assembler with `idx`, zero-fill on flush, and a `word_valid` output.
- The FSM, address counter and error logic live in `prog_loader`.

## Test plan
- Send bytes 0A 80 50 31, then 00 00 00 07 with `s_last` → two writes: addr0=0x3150800A (mv $10,%gpr0), addr1=0x07000000 (hlt). `words_loaded`=2, `done`=1, no errors. `cpu_enable` rises exactly one cycle after the second `mem_we`.
- Send a 6-byte image 11 22 33 44 55 66(last) → addr0=0x44332211, addr1=0x00006655, `err_partial`=1, `words_loaded`=2.
- `DEPTH`=4, send 24 bytes → exactly 4 writes (addr 0..3), `err_ovf`=1, all 24 bytes accepted, `words_loaded`=4, `mem_addr` never 0 after the first write.
- `s_valid` toggled every other cycle during a 3-word load → data identical to the continuous case and no `mem_we` outside word completion. Pulse `start` mid-load → ignored.
- Assert `rst` low after 2 words of a 4-word load → all outputs return to reset values asynchronously. A fresh `start` with a 1-word image writes addr0 and reaches `DONE`.
- Pulse `start` while in `DONE` → `cpu_enable`=0 on the next edge, reload overwrites from addr 0, and the error flags are cleared.
